// File: rtl/seq_1011_frame_tx.sv
// Serial frame transmitter: sync word 1011, then DATA_W payload bits MSB first,
// then GAP_CYCLES idle cycles. One payload word is accepted per frame via valid/ready.
module seq_1011_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_MAX = (DATA_W > GAP_CYCLES) ? ((DATA_W > 4) ? DATA_W : 4)
                                                 : ((GAP_CYCLES > 4) ? GAP_CYCLES : 4);
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [3:0]       SYNC_WORD = 4'b1011;
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_GAP
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_sr;
  logic               r_dout;
  logic               r_dout_valid;
  logic               r_busy;
  logic               r_ready;
  logic               r_frame_done;

  logic [DATA_W-1:0]  w_sr_shift;
  logic               w_sync_next;

  assign w_sr_shift  = r_sr << 1;
  // Sync bit that will be on the line after cnt advances by one (order 1,0,1,1).
  assign w_sync_next = SYNC_WORD[2'd2 - r_cnt[1:0]];

  // Outputs are registered alongside the state, so each branch loads the
  // values that belong to the state being entered.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge register values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sr         <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_ready      <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      // NOTE: defaults first so every path assigns these; later assignments win.
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          if (data_valid) begin
            r_state      <= S_SYNC;
            r_cnt        <= '0;
            r_sr         <= data_in;
            r_dout       <= SYNC_WORD[3];
            r_dout_valid <= 1'b1;
            r_busy       <= 1'b1;
            r_ready      <= 1'b0;
          end
        end
        S_SYNC: begin
          r_dout_valid <= 1'b1;
          if (r_cnt == SYNC_LAST) begin
            r_state      <= S_DATA;
            r_cnt        <= '0;
            r_dout       <= r_sr[DATA_W-1];
            r_frame_done <= (DATA_W == 1);
          end else begin
            r_cnt  <= r_cnt + CNT_ONE;
            r_dout <= w_sync_next;
          end
        end
        S_DATA: begin
          r_sr <= w_sr_shift;
          if (r_cnt == DATA_LAST) begin
            r_cnt <= '0;
            if (GAP_CYCLES > 0) begin
              r_state <= S_GAP;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
            end
          end else begin
            r_cnt        <= r_cnt + CNT_ONE;
            r_dout       <= w_sr_shift[DATA_W-1];
            r_dout_valid <= 1'b1;
            r_frame_done <= ((r_cnt + CNT_ONE) == DATA_LAST);
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = r_busy;
  assign data_ready = r_ready;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seq_1011_frame_tx.sv
// Directed bench for seq_1011_frame_tx: default build (8-bit, 1 gap cycle)
// and a DATA_W=1 / GAP_CYCLES=0 build sharing clock and reset.
module tb_seq_1011_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready, dout, dout_valid, busy, frame_done;

  logic [0:0] data_in2;
  logic       data_valid2;
  logic       data_ready2, dout2, dout_valid2, busy2, frame_done2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_1011_frame_tx #(.DATA_W(8), .GAP_CYCLES(1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  seq_1011_frame_tx #(.DATA_W(1), .GAP_CYCLES(0)) u_dut_w1 (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in2),
    .data_valid (data_valid2),
    .data_ready (data_ready2),
    .dout       (dout2),
    .dout_valid (dout_valid2),
    .busy       (busy2),
    .frame_done (frame_done2)
  );

  // Output bundle order: {dout, dout_valid, busy, frame_done, data_ready}
  localparam logic [4:0] IDLE_OUT = 5'b00001;

  typedef struct {
    logic       rst;
    logic       dv;
    logic [7:0] din;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[18];

  function automatic logic [4:0] active(input logic bit_val, input logic fd);
    return {bit_val, 1'b1, 1'b1, fd, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {dout,dv,busy,fd,ready}=%b, want %b", name, act, exp);
    end
  endtask

  // Called in cycle k+1 of a frame whose handshake latched p at edge k.
  // Checks cycles k+1..k+14 and leaves the bench in cycle k+14.
  task automatic expect_frame(input string name, input logic [7:0] p,
                              input bit churn, input logic hold);
    logic [4:0] exp;
    logic [3:0] sync_word;
    sync_word = 4'b1011;
    for (int c = 1; c <= 13; c++) begin
      if (c <= 4)       exp = active(sync_word[4-c], 1'b0);
      else if (c <= 12) exp = active(p[12-c], c == 12);
      else              exp = 5'b00100;
      check($sformatf("%s c%0d", name, c),
            {dout, dout_valid, busy, frame_done, data_ready}, exp);
      if (churn) begin
        data_valid = 1'($urandom);
        data_in    = 8'($urandom);
      end else begin
        data_valid = hold;
      end
      step();
    end
    check($sformatf("%s c14", name),
          {dout, dout_valid, busy, frame_done, data_ready}, IDLE_OUT);
  endtask

  task automatic start_frame(input logic [7:0] p);
    data_in    = p;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] pay;
    rst         = 1'b1;
    data_in     = 8'h00;
    data_valid  = 1'b0;
    data_in2    = 1'b0;
    data_valid2 = 1'b0;
    @(negedge clk);

    // Reset with data_valid high, then a single 0xA5 frame.
    for (int i = 0; i < 3; i++) vecs[i] = '{1'b1, 1'b1, 8'hA5, IDLE_OUT};
    vecs[3] = '{1'b0, 1'b0, 8'hA5, IDLE_OUT};
    vecs[4] = '{1'b0, 1'b1, 8'hA5, active(1'b1, 1'b0)};
    vecs[5] = '{1'b0, 1'b0, 8'h00, active(1'b0, 1'b0)};
    vecs[6] = '{1'b0, 1'b0, 8'h00, active(1'b1, 1'b0)};
    vecs[7] = '{1'b0, 1'b0, 8'h00, active(1'b1, 1'b0)};
    pay = 8'hA5;
    for (int i = 0; i < 8; i++)
      vecs[8+i] = '{1'b0, 1'b0, 8'h00, active(pay[7-i], i == 7)};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 5'b00100};
    vecs[17] = '{1'b0, 1'b0, 8'h00, IDLE_OUT};

    for (int i = 0; i < 18; i++) begin
      rst        = vecs[i].rst;
      data_valid = vecs[i].dv;
      data_in    = vecs[i].din;
      step();
      check($sformatf("vec%0d", i),
            {dout, dout_valid, busy, frame_done, data_ready}, vecs[i].exp);
    end

    // Back to back with data_valid held: 0x00 then 0xFF, second sync 14 cycles later.
    data_in    = 8'h00;
    data_valid = 1'b1;
    step();
    data_in = 8'hFF;
    expect_frame("b2b0", 8'h00, 1'b0, 1'b1);
    step();
    expect_frame("b2b1", 8'hFF, 1'b0, 1'b0);
    step();
    check("b2b_idle", {dout, dout_valid, busy, frame_done, data_ready}, IDLE_OUT);

    // Input churn during a 0x3C frame must not disturb the payload or start a frame.
    start_frame(8'h3C);
    expect_frame("churn", 8'h3C, 1'b1, 1'b0);
    data_valid = 1'b0;
    step();
    check("churn_nohs", {dout, dout_valid, busy, frame_done, data_ready}, IDLE_OUT);

    // Reset at payload bit 3 of 0x5A, then a clean 0xC3 frame.
    start_frame(8'h5A);
    repeat (7) step();
    check("rst_bit3", {dout, dout_valid, busy, frame_done, data_ready}, active(1'b1, 1'b0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_idle", {dout, dout_valid, busy, frame_done, data_ready}, IDLE_OUT);
    step();
    check("rst_stay", {dout, dout_valid, busy, frame_done, data_ready}, IDLE_OUT);
    start_frame(8'hC3);
    expect_frame("post_rst", 8'hC3, 1'b0, 1'b0);

    // DATA_W=1, GAP_CYCLES=0: 1,0,1,1,1 then ready in the 6th cycle.
    data_in2    = 1'b1;
    data_valid2 = 1'b1;
    step();
    data_valid2 = 1'b0;
    data_in2    = 1'b0;
    begin
      logic [4:0] w1_bits;
      w1_bits = 5'b10111;
      for (int c = 1; c <= 5; c++) begin
        check($sformatf("w1 c%0d", c),
              {dout2, dout_valid2, busy2, frame_done2, data_ready2},
              active(w1_bits[5-c], c == 5));
        step();
      end
    end
    check("w1 c6", {dout2, dout_valid2, busy2, frame_done2, data_ready2}, IDLE_OUT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_1011_frame_tx.md
# seq_1011_frame_tx

Serial frame transmitter that emits the 4-bit sync word 1011, followed by a parallel payload shifted out MSB first, then an idle gap. It is the sending end for the team's non-overlapping 1011 Moore sequence detector, which locks onto the sync word. A valid/ready handshake on the parallel side accepts one payload word per frame. All outputs are Moore decodes of registered state and counters.

## Interface
- DATA_W, 8: payload width in bits; legal range 1..32.
- GAP_CYCLES, 1: idle cycles after the last payload bit before the next handshake is possible; legal range 0..15.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high; has priority over every other input.
- data_in  input  DATA_W  payload word; sampled only on a handshake edge.
- data_valid  input  1  upstream has a payload word on data_in.
- data_ready  output  1  block can accept a word; high only in IDLE.
- dout  output  1  serial line bit.
- dout_valid  output  1  dout carries a sync or payload bit this cycle.
- busy  output  1  frame in progress (SYNC, DATA or GAP).
- frame_done  output  1  one-cycle pulse, high during the last payload bit.

## Operation
- States: IDLE, SYNC, DATA, GAP. Bit counter cnt is sized for max(4, DATA_W, GAP_CYCLES). Shift register sr is DATA_W bits.
- Reset: state=IDLE, cnt=0, sr=0. Outputs after the reset edge: data_ready=1, dout=0, dout_valid=0, busy=0, frame_done=0.
- Handshake: data_valid=1 and data_ready=1 at a rising edge with rst=0. On that edge, sr<=data_in, cnt<=0 and state<=SYNC.
- IDLE: dout=0 and dout_valid=0. data_valid=0 keeps the block in IDLE.
- SYNC: dout = sync bit cnt (order 1,0,1,1). dout_valid=1. Once cnt=3, the next state is DATA with cnt<=0.
- DATA: dout=sr[DATA_W-1] and dout_valid=1. Each edge shifts sr left by one with 0 fill and increments cnt. frame_done=1 when cnt=DATA_W-1. After that cycle:
  - GAP_CYCLES>0: go to GAP with cnt<=0.
  - GAP_CYCLES=0: go to IDLE.
- GAP: dout=0 and dout_valid=0. Once cnt=GAP_CYCLES-1, go to IDLE.
- busy=1 in SYNC, DATA and GAP. data_ready is the exact complement of busy.
- Inputs outside IDLE: data_valid and data_in are ignored. The latched payload is unaffected by changes on data_in mid-frame.
- The block does not stuff bits. A payload containing 1011 can false-trigger a detector, and that is upstream's responsibility.

## Timing
- Handshake at edge k:
  - Sync bits in cycles k+1..k+4.
  - Payload bits in cycles k+5..k+4+DATA_W.
  - Gap in the next GAP_CYCLES cycles.
  - data_ready=1 again in cycle k+5+DATA_W+GAP_CYCLES.
- Minimum frame period is 5+DATA_W+GAP_CYCLES cycles. With the defaults this is 14.
- If data_valid is held high, the next handshake happens in the first IDLE cycle, so frames run back to back with exactly one IDLE cycle between them.
- Latency from handshake edge to the first dout_valid=1 cycle is 1 cycle.
- Reset mid-frame, any state: the next edge returns to IDLE with all outputs at their reset values and the payload discarded. No partial frame resumes.
- rst=1 and a handshake on the same edge: rst wins and the word is not accepted.

## Test plan
- Reset: hold rst 3 cycles with data_valid=1. Required: no handshake; data_ready=1, dout=0, dout_valid=0, busy=0, frame_done=0 after release.
- Single frame, defaults, data_in=0xA5:
  - dout over cycles k+1..k+12 = 1,0,1,1,1,0,1,0,0,1,0,1 with dout_valid=1 throughout.
  - frame_done only in cycle k+12; cycle k+13 is gap; data_ready=1 in cycle k+14.
- Back to back: hold data_valid=1 with 0x00 then 0xFF. Required: second sync starts exactly 14 cycles after the first; payload bits are 8×0 then 8×1.
- Mid-frame input churn: toggle data_valid and randomize data_in every cycle during a 0x3C frame. Required: serial payload is exactly 0,0,1,1,1,1,0,0 and no extra handshake occurs.
- Reset during DATA: assert rst for one cycle at payload bit 3. Required: next cycle state is IDLE with dout_valid=0 and data_ready=1; the next frame is complete and correct.
- Parameter corner, DATA_W=1, GAP_CYCLES=0, data_in=1: dout=1,0,1,1,1 over 5 cycles, frame_done on the 5th, data_ready=1 in the 6th cycle.
